key_tone_gate: RTL and testbench
================================

Name: key_tone_gate

Overview:
- Downstream consumer of the per-note square-wave generators (one generator per piano key, 50 MHz system clock).
- Debounces the raw key buttons and picks one active note using last-pressed priority.
- Gates that note's square wave onto the single speaker pin.
- Switches between notes and turns the speaker off only while the outgoing wave is low, so no runt pulses are produced.

Parameters:
- NUM_KEYS, 13, number of keys and note-wave inputs (index 0 = lowest note).
- IDX_W, 4, width of the note index; must satisfy 2^IDX_W >= NUM_KEYS.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles before a key level is accepted (10 ms at 50 MHz).
- HOLD_CYCLES, 2500000, release tail: cycles the last note keeps sounding after all keys are released.
- CNT_W, 22, counter width; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- key_raw  in  NUM_KEYS  raw push-buttons, asynchronous, 1 = pressed.
- note_wave  in  NUM_KEYS  square waves from the note generators, synchronous to clk.
- speaker  out  1  gated tone to the speaker pin; registered.
- active_note  out  IDX_W  index of the selected note; registered.
- note_on  out  1  1 while a key is held and sounding (PLAY/SWITCH).

Behaviour:
- One clock, clk. Reset is synchronous and active-high, named reset.
- Reset values:
  - speaker = 0, active_note = 0, note_on = 0.
  - State = IDLE; all synchronizer flops, key_db bits and counters = 0.
  - Keys held through reset are seen as fresh presses once debounced.
- Input conditioning:
  - Each key_raw bit passes a 2-flop synchronizer, giving ks.
  - Each key has its own debounce counter. When ks differs from key_db, the counter increments; when they match, it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1, key_db takes ks and the counter clears.
  - Latency from a raw edge to the key_db change = 2 + DEBOUNCE_CYCLES cycles. Bounces shorter than that are ignored.
- Events, computed each cycle:
  - press = key_db & ~key_db_prev.
  - held = key_db.
  - When several press bits are set in one cycle, the highest index wins.
- States: IDLE, PLAY, SWITCH, TAIL.
  - IDLE → PLAY on any press. active_note takes the winning index immediately.
  - PLAY, new press on index k != active_note → load pending = k, go to SWITCH.
  - PLAY, new press on index k == active_note → stay in PLAY.
  - PLAY, active key released and other keys still held → pending = highest held index, go to SWITCH.
  - PLAY, no keys held → clear the hold counter, go to TAIL.
  - SWITCH: a later press overwrites pending. If pending's key is released, pending becomes the highest held index. If nothing is held, go to TAIL.
  - SWITCH, on the first cycle where note_wave[active_note] == 0 → active_note = pending, go to PLAY.
  - TAIL: the hold counter increments each cycle.
  - TAIL, any press → pending = winner, go to SWITCH.
  - TAIL, after the counter reaches HOLD_CYCLES-1 → wait until note_wave[active_note] == 0, then go to IDLE.
- Outputs:
  - speaker <= note_wave[active_note] in PLAY, SWITCH and TAIL; speaker <= 0 in IDLE. Latency is 1 cycle from note_wave.
  - note_on = 1 in PLAY and SWITCH, 0 in IDLE and TAIL.
  - active_note holds its last value in IDLE.
- Boundary conditions:
  - A note_wave stuck high keeps SWITCH and TAIL waiting indefinitely. This is intended.
  - Reset asserted mid-SWITCH or mid-TAIL returns to reset values on the next clock edge.
  - A press and the release of the active key in the same cycle: the press wins.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, note_wave[i] toggling every i+2 cycles):
- Reset and idle: reset high for 3 cycles with key_raw=0 → speaker=0, note_on=0, active_note=0, state IDLE for 50 cycles.
- Debounce: key 3 pulses high for 3 cycles, then stays high → the 3-cycle pulse is ignored. note_on rises exactly 2+4+1 cycles after the stable edge, active_note=3, and speaker follows note_wave[3] delayed by 1 cycle.
- Glitch-free switch: holding key 3, press key 7 while note_wave[3]=1 → active_note stays 3 until note_wave[3] is sampled 0, then becomes 7. speaker shows no high pulse shorter than note_wave[3]'s remaining high time.
- Simultaneous presses and fallback: from IDLE, press keys 2 and 9 in the same cycle → active_note=9. Release 9 while 2 is still held → active_note=2 at the next low of wave 9.
- Release tail: release all keys → note_on=0 immediately, speaker keeps toggling for 8 cycles, then goes to 0 and stays 0 at the first low of the wave. Pressing key 5 during the tail instead → SWITCH, then active_note=5.
- Reset mid-operation: assert reset during SWITCH → next cycle speaker=0, note_on=0, active_note=0. A key held through reset re-triggers PLAY 2+4+1 cycles after reset deasserts.

Source files
------------

// File: rtl/key_tone_gate.sv
// key_tone_gate: debounces the piano keys, picks the last-pressed note and gates its
// square wave onto the speaker, changing or silencing notes only while the wave is low.
module key_tone_gate #(
  parameter int NUM_KEYS        = 13,
  parameter int IDX_W           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 2500000,
  parameter int CNT_W           = 22
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic [NUM_KEYS-1:0] note_wave,
  output logic                speaker,
  output logic [IDX_W-1:0]    active_note,
  output logic                note_on
);

  // state  | meaning
  // IDLE   | silent, waiting for a key press
  // PLAY   | active note sounding while its key is held
  // SWITCH | new note chosen, waiting for a low of the outgoing wave
  // TAIL   | all keys released, last note rings out for the hold time
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_SWITCH = 2'd2,
    S_TAIL   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_ks;
  logic [NUM_KEYS-1:0] r_key_db;
  logic [NUM_KEYS-1:0] r_key_db_prev;
  logic [CNT_W-1:0]    r_db_cnt [NUM_KEYS];

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_active;
  logic [IDX_W-1:0]    w_active_nxt;
  logic [IDX_W-1:0]    r_pending;
  logic [IDX_W-1:0]    w_pending_nxt;
  logic [IDX_W-1:0]    w_target;
  logic [CNT_W-1:0]    r_hold_cnt;
  logic [CNT_W-1:0]    w_hold_nxt;
  logic                r_speaker;

  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_held;
  logic [IDX_W-1:0]    w_press_idx;
  logic [IDX_W-1:0]    w_held_idx;
  logic                w_any_press;
  logic                w_any_held;
  logic                w_wave_cur;

  // Keys held through reset start from key_db = 0 and re-debounce as fresh presses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1       <= '0;
      r_ks          <= '0;
      r_key_db      <= '0;
      r_key_db_prev <= '0;
      for (int i = 0; i < NUM_KEYS; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1       <= key_raw;
      r_ks          <= r_sync1;
      r_key_db_prev <= r_key_db;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (r_ks[i] == r_key_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_key_db[i] <= r_ks[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_press     = r_key_db & ~r_key_db_prev;
  assign w_held      = r_key_db;
  assign w_any_press = |w_press;
  assign w_any_held  = |w_held;
  assign w_wave_cur  = note_wave[r_active];

  // Ascending scan so the highest set index wins.
  always_comb begin
    w_press_idx = '0;
    w_held_idx  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (w_press[i]) w_press_idx = IDX_W'(i);
      if (w_held[i])  w_held_idx  = IDX_W'(i);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_active_nxt  = r_active;
    w_pending_nxt = r_pending;
    w_hold_nxt    = r_hold_cnt;
    w_target      = r_pending;
    case (r_state)
      S_IDLE: begin
        if (w_any_press) begin
          w_active_nxt = w_press_idx;
          w_state_nxt  = S_PLAY;
        end
      end
      S_PLAY: begin
        if (w_any_press) begin
          if (w_press_idx != r_active) begin
            w_pending_nxt = w_press_idx;
            w_state_nxt   = S_SWITCH;
          end
        end else if (!w_held[r_active]) begin
          if (w_any_held) begin
            w_pending_nxt = w_held_idx;
            w_state_nxt   = S_SWITCH;
          end else begin
            w_hold_nxt  = '0;
            w_state_nxt = S_TAIL;
          end
        end
      end
      S_SWITCH: begin
        if (w_any_press) begin
          w_target = w_press_idx;
        end else if (!w_held[r_pending]) begin
          w_target = w_held_idx;
        end
        if (!w_any_held) begin
          w_hold_nxt  = '0;
          w_state_nxt = S_TAIL;
        end else if (!w_wave_cur) begin
          w_active_nxt = w_target;
          w_state_nxt  = S_PLAY;
        end else begin
          w_pending_nxt = w_target;
        end
      end
      S_TAIL: begin
        if (w_any_press) begin
          w_pending_nxt = w_press_idx;
          w_state_nxt   = S_SWITCH;
        end else if (r_hold_cnt != HOLD_LAST) begin
          w_hold_nxt = r_hold_cnt + CNT_W'(1);
        end else if (!w_wave_cur) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_active   <= '0;
      r_pending  <= '0;
      r_hold_cnt <= '0;
      r_speaker  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_active   <= w_active_nxt;
      r_pending  <= w_pending_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_speaker  <= (r_state == S_IDLE) ? 1'b0 : w_wave_cur;
    end
  end

  assign speaker     = r_speaker;
  assign active_note = r_active;
  assign note_on     = (r_state == S_PLAY) || (r_state == S_SWITCH);

endmodule

// File: tb/tb_key_tone_gate.sv
// Directed bench for key_tone_gate with short debounce/hold times and
// note_wave[i] toggling every i+2 cycles.
module tb_key_tone_gate;

  localparam int NK = 13;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] note_wave = '0;
  logic          speaker;
  logic [IW-1:0] active_note;
  logic          note_on;

  logic [NK-1:0] w_prev;
  int            wcnt [NK] = '{default: 0};
  int            checks   = 0;
  int            failures = 0;

  key_tone_gate #(
    .NUM_KEYS(NK), .IDX_W(IW), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .CNT_W(22)
  ) dut (
    .clk(clk), .reset(reset), .key_raw(key_raw), .note_wave(note_wave),
    .speaker(speaker), .active_note(active_note), .note_on(note_on)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < NK; i++) begin
      if (wcnt[i] == i + 1) begin
        wcnt[i]      <= 0;
        note_wave[i] <= ~note_wave[i];
      end else begin
        wcnt[i] <= wcnt[i] + 1;
      end
    end
  end

  // w_prev holds the wave values the DUT samples at the coming edge.
  task automatic tick();
    w_prev = note_wave;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_rise(input int idx);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      tick();
      if (note_wave[idx] && !w_prev[idx]) got = 1'b1;
    end
    chk("wave_rise_found", got, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic done;
    reset   = 1'b1;
    key_raw = '0;
    repeat (3) tick();
    chk("rst_speaker", speaker, 0);
    chk("rst_note_on", note_on, 0);
    chk("rst_active", active_note, 0);
    reset = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      chk("idle_speaker", speaker, 0);
      chk("idle_note_on", note_on, 0);
      chk("idle_active", active_note, 0);
    end

    // 3-cycle bounce must be rejected
    key_raw[3] = 1'b1;
    repeat (3) tick();
    key_raw[3] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("bounce_ignored", note_on, 0);
    end
    key_raw[3] = 1'b1;
    repeat (6) tick();
    chk("db_not_yet", note_on, 0);
    tick();
    chk("db_note_on", note_on, 1);
    chk("db_active", active_note, 3);
    chk("db_speaker_first", speaker, 0);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("play3_speaker", speaker, w_prev[3]);
    end

    // press key 7 timed so SWITCH starts on a rising edge of wave 3
    wait_rise(3);
    repeat (3) tick();
    key_raw[7] = 1'b1;
    repeat (7) tick();
    chk("sw_note_on", note_on, 1);
    chk("sw_active_hold", active_note, 3);
    chk("sw_speaker_low", speaker, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("sw_speaker_full_high", speaker, 1);
      chk("sw_active_wait", active_note, 3);
    end
    tick();
    chk("sw_active_new", active_note, 7);
    chk("sw_speaker_gap", speaker, 0);
    chk("sw_note_on_play", note_on, 1);
    tick();
    chk("play7_speaker", speaker, w_prev[7]);

    // release everything: tail then idle
    key_raw = '0;
    repeat (6) tick();
    chk("tail_pre_note_on", note_on, 1);
    tick();
    chk("tail_note_on", note_on, 0);
    done = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (done) begin
        chk("tail_idle_speaker", speaker, 0);
      end else begin
        chk("tail_speaker", speaker, w_prev[7]);
        if (k >= 8 && !w_prev[7]) done = 1'b1;
      end
      chk("tail_note_on_low", note_on, 0);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("post_tail_speaker", speaker, 0);
    end
    chk("idle_active_kept", active_note, 7);

    // simultaneous presses, highest index wins; then fallback to key 2
    key_raw[2] = 1'b1;
    key_raw[9] = 1'b1;
    repeat (6) tick();
    chk("simul_not_yet", note_on, 0);
    tick();
    chk("simul_note_on", note_on, 1);
    chk("simul_active", active_note, 9);
    repeat (3) tick();
    key_raw[9] = 1'b0;
    repeat (7) tick();
    chk("fb_active_hold", active_note, 9);
    chk("fb_note_on", note_on, 1);
    done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (!done) begin
        if (!w_prev[9]) begin
          chk("fb_active_switch", active_note, 2);
          done = 1'b1;
        end else begin
          chk("fb_active_wait", active_note, 9);
        end
      end
    end
    chk("fb_active_final", active_note, 2);

    // release key 2, press key 5 during the tail
    key_raw = '0;
    tick();
    key_raw[5] = 1'b1;
    repeat (5) tick();
    chk("t5_play", note_on, 1);
    tick();
    chk("t5_tail", note_on, 0);
    chk("t5_tail_speaker", speaker, w_prev[2]);
    tick();
    chk("t5_switch", note_on, 1);
    chk("t5_active_hold", active_note, 2);
    done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!done) begin
        if (!w_prev[2]) begin
          chk("t5_active_switch", active_note, 5);
          done = 1'b1;
        end else begin
          chk("t5_active_wait", active_note, 2);
        end
      end
    end
    chk("t5_active_final", active_note, 5);

    // reset during SWITCH, keys held through reset
    wait_rise(5);
    repeat (7) tick();
    key_raw[11] = 1'b1;
    repeat (7) tick();
    chk("mid_sw_note_on", note_on, 1);
    chk("mid_sw_active", active_note, 5);
    reset = 1'b1;
    tick();
    chk("mid_rst_speaker", speaker, 0);
    chk("mid_rst_note_on", note_on, 0);
    chk("mid_rst_active", active_note, 0);
    tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("retrig_not_yet", note_on, 0);
    tick();
    chk("retrig_note_on", note_on, 1);
    chk("retrig_active", active_note, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
